// File: rtl/branch_resolve_update.sv
// Checks fetch predictions in order against execute outcomes, trains a 2-bit BHT, issues redirects.
// Redirect/flush are registered one cycle after a mispredict; pred_ready drops when full or recovering.
module branch_resolve_update #(
   parameter int size         = 32,
   parameter int DEPTH        = 4,
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pred_valid,
   input  logic [size-1:0] pred_pc,
   input  logic            pred_taken,
   input  logic [size-1:0] pred_target,
   output logic            pred_ready,
   input  logic [size-1:0] lookup_pc,
   output logic            lookup_taken,
   input  logic            res_valid,
   input  logic            res_taken,
   input  logic [size-1:0] res_target,
   output logic            redirect_valid,
   output logic [size-1:0] redirect_pc,
   output logic            flush,
   output logic            res_error,
   output logic [15:0]     mispredict_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(BHT_ENTRIES);
   localparam int RW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, REDIRECT, RECOVER} state_t;

   state_t          state;
   logic [size-1:0] pc_q     [DEPTH];
   logic            taken_q  [DEPTH];
   logic [size-1:0] target_q [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic [RW-1:0]   rec_cnt;
   logic [1:0]      bht [BHT_ENTRIES];

   logic            full, empty, do_push, do_pop, mispredict;
   logic [size-1:0] head_pc, head_target, correct_pc;
   logic            head_taken;
   logic [IW-1:0]   head_idx;
   logic            unused_lookup_bits;

   assign full        = (count == (PW+1)'(DEPTH));
   assign empty       = (count == '0);
   assign pred_ready  = ~full & (state == RUN);
   assign do_push     = pred_valid & pred_ready;
   assign do_pop      = (state == RUN) & res_valid & ~empty;
   assign head_pc     = pc_q[rd_ptr];
   assign head_taken  = taken_q[rd_ptr];
   assign head_target = target_q[rd_ptr];
   assign head_idx    = head_pc[IW+1:2];
   assign mispredict  = (res_taken != head_taken) | (res_taken & (res_target != head_target));
   assign correct_pc  = res_taken ? res_target : head_pc + size'(4);

   // Lookup reads the registered counter, so a same-cycle training write is not yet visible.
   assign lookup_taken       = bht[lookup_pc[IW+1:2]][1];
   assign unused_lookup_bits = ^{lookup_pc[size-1:IW+2], lookup_pc[1:0]};

   always_ff @(posedge clk) begin
      if (do_push && !(do_pop && mispredict)) begin
         pc_q[wr_ptr]     <= pred_pc;
         taken_q[wr_ptr]  <= pred_taken;
         target_q[wr_ptr] <= pred_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= RUN;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         rec_cnt        <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         res_error      <= 1'b0;
         mispredict_cnt <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else begin
         redirect_valid <= 1'b0;
         flush          <= 1'b0;
         case (state)
            RUN: begin
               if (res_valid && empty) res_error <= 1'b1;
               if (do_pop) begin
                  if (res_taken) begin
                     if (bht[head_idx] != 2'b11) bht[head_idx] <= bht[head_idx] + 2'b01;
                  end else if (bht[head_idx] != 2'b00) begin
                     bht[head_idx] <= bht[head_idx] - 2'b01;
                  end
               end
               // A mispredict discards everything queued, including a record pushed this cycle.
               if (do_pop && mispredict) begin
                  wr_ptr         <= '0;
                  rd_ptr         <= '0;
                  count          <= '0;
                  state          <= REDIRECT;
                  redirect_valid <= 1'b1;
                  flush          <= 1'b1;
                  redirect_pc    <= correct_pc;
                  if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
               end else begin
                  if (do_push) wr_ptr <= wr_ptr + 1'b1;
                  if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                  case ({do_push, do_pop})
                     2'b10:   count <= count + 1'b1;
                     2'b01:   count <= count - 1'b1;
                     default: count <= count;
                  endcase
               end
            end
            REDIRECT: begin
               state   <= RECOVER;
               rec_cnt <= '0;
            end
            RECOVER: begin
               if (rec_cnt == RW'(FLUSH_CYCLES - 1)) begin
                  state   <= RUN;
                  rec_cnt <= '0;
               end else begin
                  rec_cnt <= rec_cnt + 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_branch_resolve_update.sv
// Bench for branch_resolve_update: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_update;
   localparam int DEPTH = 4;
   localparam int FLUSH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
   logic [31:0] pred_pc = '0, pred_target = '0, lookup_pc = '0, res_target = '0;
   logic        pred_ready, lookup_taken, redirect_valid, flush, res_error;
   logic [31:0] redirect_pc;
   logic [15:0] mispredict_cnt;

   branch_resolve_update dut (
      .clk(clk), .reset(reset),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .res_error(res_error), .mispredict_cnt(mispredict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] target;
   } rec_t;

   rec_t        q[$];
   int          bht_m [64];
   int          mcnt;
   bit          err_m;
   bit          exp_redir;
   logic [31:0] exp_rpc;
   int          blocked;
   logic        pre_lt;
   int          total = 0;
   int          bad = 0;

   function automatic bit model_lookup(input logic [31:0] pc);
      return bht_m[(pc >> 2) % 64] >= 2;
   endfunction

   function automatic bit model_ready();
      return (blocked == 0) && (q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      q.delete();
      foreach (bht_m[i]) bht_m[i] = 1;
      mcnt = 0; err_m = 0; exp_redir = 0; exp_rpc = '0; blocked = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of inputs, advance the model, and land just after the clock edge.
   task automatic tick(input bit pv, input logic [31:0] ppc, input bit pt, input logic [31:0] ptgt,
                       input bit rv, input bit rt, input logic [31:0] rtgt);
      bit ready_m;
      rec_t h;
      int idx;
      pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
      res_valid = rv; res_taken = rt; res_target = rtgt;
      #1;
      pre_lt = lookup_taken;
      exp_redir = 0;
      if (blocked > 0) begin
         blocked--;
      end else begin
         ready_m = q.size() < DEPTH;
         if (rv && q.size() == 0) begin
            err_m = 1;
         end else if (rv) begin
            h = q.pop_front();
            idx = (h.pc >> 2) % 64;
            if (rt) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
            else    bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
            if ((rt != h.taken) || (rt && rtgt != h.target)) begin
               q.delete();
               exp_redir = 1;
               exp_rpc = rt ? rtgt : h.pc + 32'd4;
               if (mcnt < 65535) mcnt++;
               blocked = 1 + FLUSH;
            end
         end
         if (pv && ready_m && !exp_redir) q.push_back('{ppc, pt, ptgt});
      end
      @(posedge clk); #1;
      pred_valid = 1'b0; res_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         lookup_pc = $urandom; #1;
         total++;
         if (lookup_taken !== 1'b0) begin bad++; $display("FAIL reset_lookup: got %0b want 0", lookup_taken); end
      end
      total++;
      if (pred_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", pred_ready); end
      total++;
      if (mispredict_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0h want 0", mispredict_cnt); end
      total++;
      if (res_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", res_error); end
      total++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h0) begin
         bad++; $display("FAIL reset_redirect: got v=%0b f=%0b pc=%0h want 0 0 0", redirect_valid, flush, redirect_pc);
      end
   endtask

   task automatic test_correct_predict();
      tick(1, 32'h100, 1, 32'h180, 0, 0, '0);
      lookup_pc = 32'h100;
      tick(0, '0, 0, '0, 1, 1, 32'h180);
      total++;
      if (pre_lt !== 1'b0) begin bad++; $display("FAIL same_cycle_lookup: got %0b want 0", pre_lt); end
      total++;
      if (redirect_valid !== 1'b0) begin bad++; $display("FAIL correct_no_redirect: got %0b want 0", redirect_valid); end
      total++;
      if (lookup_taken !== 1'b1) begin bad++; $display("FAIL bht_train_100: got %0b want 1", lookup_taken); end
   endtask

   task automatic test_mispredict();
      tick(1, 32'h200, 0, '0, 0, 0, '0);
      tick(0, '0, 0, '0, 1, 1, 32'h240);
      total++;
      if (redirect_valid !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h240) begin
         bad++; $display("FAIL mispredict_redirect: got v=%0b f=%0b pc=%0h want 1 1 240", redirect_valid, flush, redirect_pc);
      end
      total++;
      if (mispredict_cnt !== 16'd1) begin bad++; $display("FAIL mispredict_cnt: got %0d want 1", mispredict_cnt); end
      total++;
      if (pred_ready !== 1'b0) begin bad++; $display("FAIL redirect_ready: got %0b want 0", pred_ready); end
      for (int i = 0; i < FLUSH; i++) begin
         tick(1, 32'h500, 1, 32'h540, 1, 1, 32'h0);
         total++;
         if (pred_ready !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 32'h240) begin
            bad++; $display("FAIL recover_state: got r=%0b v=%0b f=%0b pc=%0h want 0 0 0 240", pred_ready, redirect_valid, flush, redirect_pc);
         end
      end
      idle(1);
      total++;
      if (pred_ready !== 1'b1) begin bad++; $display("FAIL recover_exit_ready: got %0b want 1", pred_ready); end
      lookup_pc = 32'h200; #1;
      total++;
      if (lookup_taken !== 1'b1) begin bad++; $display("FAIL bht_train_200: got %0b want 1", lookup_taken); end
      // FIFO must be empty: exactly DEPTH pushes fill it.
      for (int i = 0; i < DEPTH; i++) tick(1, 32'h800 + 32'(i * 4), 0, '0, 0, 0, '0);
      total++;
      if (pred_ready !== 1'b0) begin bad++; $display("FAIL flush_emptied: got %0b want 0", pred_ready); end
      for (int i = 0; i < DEPTH; i++) tick(0, '0, 0, '0, 1, 0, '0);
   endtask

   task automatic test_target_mismatch();
      tick(1, 32'h300, 1, 32'h340, 0, 0, '0);
      tick(0, '0, 0, '0, 1, 1, 32'h344);
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h344) begin
         bad++; $display("FAIL target_mismatch: got v=%0b pc=%0h want 1 344", redirect_valid, redirect_pc);
      end
      idle(1 + FLUSH);
      tick(1, 32'h300, 1, 32'h340, 0, 0, '0);
      tick(0, '0, 0, '0, 1, 0, '0);
      total++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin
         bad++; $display("FAIL dir_mismatch: got v=%0b pc=%0h want 1 304", redirect_valid, redirect_pc);
      end
      total++;
      if (mispredict_cnt !== 16'd3) begin bad++; $display("FAIL cnt_after_three: got %0d want 3", mispredict_cnt); end
      idle(1 + FLUSH);
   endtask

   task automatic test_saturation_and_reset();
      lookup_pc = 32'h400;
      for (int i = 0; i < 5; i++) begin
         tick(1, 32'h400, 1, 32'h480, 0, 0, '0);
         tick(0, '0, 0, '0, 1, 1, 32'h480);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1, 32'h400, 0, '0, 0, 0, '0);
         tick(0, '0, 0, '0, 1, 0, '0);
         total++;
         if (lookup_taken !== model_lookup(32'h400) || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL sat_nt_%0d: got lt=%0b v=%0b want lt=%0b v=0", i, lookup_taken, redirect_valid, model_lookup(32'h400));
         end
      end
      total++;
      if (lookup_taken !== 1'b0) begin bad++; $display("FAIL sat_zero: got %0b want 0", lookup_taken); end
      tick(1, 32'h400, 0, '0, 0, 0, '0);
      tick(0, '0, 0, '0, 1, 1, 32'h480);
      idle(1);
      do_reset();
      total++;
      if (pred_ready !== 1'b1 || redirect_valid !== 1'b0 || mispredict_cnt !== 16'd0) begin
         bad++; $display("FAIL reset_in_recover: got r=%0b v=%0b c=%0d want 1 0 0", pred_ready, redirect_valid, mispredict_cnt);
      end
      lookup_pc = 32'h200; #1;
      total++;
      if (lookup_taken !== 1'b0) begin bad++; $display("FAIL bht_reset_200: got %0b want 0", lookup_taken); end
      tick(1, 32'h100, 1, 32'h180, 0, 0, '0);
      tick(0, '0, 0, '0, 1, 1, 32'h180);
      total++;
      if (redirect_valid !== 1'b0 || pred_ready !== 1'b1) begin
         bad++; $display("FAIL run_after_reset: got v=%0b r=%0b want 0 1", redirect_valid, pred_ready);
      end
   endtask

   task automatic test_full_and_error();
      do_reset();
      for (int i = 0; i < DEPTH; i++) tick(1, 32'h600 + 32'(i * 4), 1, 32'h700, 0, 0, '0);
      total++;
      if (pred_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", pred_ready); end
      tick(1, 32'h610, 1, 32'h700, 1, 1, 32'h700);
      total++;
      if (pred_ready !== 1'b1 || redirect_valid !== 1'b0) begin
         bad++; $display("FAIL full_push_refused: got r=%0b v=%0b want 1 0", pred_ready, redirect_valid);
      end
      for (int i = 0; i < DEPTH - 1; i++) tick(0, '0, 0, '0, 1, 1, 32'h700);
      total++;
      if (res_error !== 1'b0) begin bad++; $display("FAIL err_early: got %0b want 0", res_error); end
      tick(0, '0, 0, '0, 1, 1, 32'h700);
      total++;
      if (res_error !== 1'b1 || redirect_valid !== 1'b0) begin
         bad++; $display("FAIL empty_resolve: got e=%0b v=%0b want 1 0", res_error, redirect_valid);
      end
      idle(2);
      total++;
      if (res_error !== 1'b1 || mispredict_cnt !== 16'd0) begin
         bad++; $display("FAIL err_sticky: got e=%0b c=%0d want 1 0", res_error, mispredict_cnt);
      end
   endtask

   task automatic test_random();
      logic [31:0] pc, tgt, rtgt;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         pc   = 32'h1000 + 32'($urandom_range(0, 15) * 4);
         tgt  = 32'h2000 + 32'($urandom_range(0, 1) * 4);
         rtgt = 32'h2000 + 32'($urandom_range(0, 1) * 4);
         tick($urandom_range(0, 1), pc, $urandom_range(0, 1), tgt,
              $urandom_range(0, 2) == 0, $urandom_range(0, 1), rtgt);
         total++;
         if (redirect_valid !== exp_redir || flush !== exp_redir) begin
            bad++; $display("FAIL rnd_redirect@%0d: got v=%0b f=%0b want %0b", n, redirect_valid, flush, exp_redir);
         end
         total++;
         if (redirect_pc !== exp_rpc) begin bad++; $display("FAIL rnd_rpc@%0d: got %0h want %0h", n, redirect_pc, exp_rpc); end
         total++;
         if (pred_ready !== model_ready()) begin bad++; $display("FAIL rnd_ready@%0d: got %0b want %0b", n, pred_ready, model_ready()); end
         total++;
         if (mispredict_cnt !== 16'(mcnt) || res_error !== err_m) begin
            bad++; $display("FAIL rnd_cnt_err@%0d: got c=%0d e=%0b want c=%0d e=%0b", n, mispredict_cnt, res_error, mcnt, err_m);
         end
         lookup_pc = 32'h1000 + 32'($urandom_range(0, 15) * 4); #1;
         total++;
         if (lookup_taken !== model_lookup(lookup_pc)) begin
            bad++; $display("FAIL rnd_lookup@%0d: got %0b want %0b", n, lookup_taken, model_lookup(lookup_pc));
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_correct_predict();
      test_mispredict();
      test_target_mismatch();
      test_saturation_and_reset();
      test_full_and_error();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
